// File: rtl/wb_ext_decoder.sv
// wb_ext_decoder: registered Wishbone decoder / response mux from the SERV external bus to up to 4 slaves.
// Latency: request -> slave strobe 1 cycle, slave ack -> master ack 1 cycle; unmapped -> error ack 1 cycle.
// Backpressure: one access in flight, requests accepted only in IDLE; define WB_DEC_TIMEOUT_EN for the hung-slave timeout.
`timescale 1ns/1ps
module wb_ext_decoder #(
    parameter logic [31:0] BASE0    = 32'h4000_0000,
    parameter logic [31:0] MASK0    = 32'hFFFF_FF00,
    parameter logic [31:0] BASE1    = 32'h4000_0110,
    parameter logic [31:0] MASK1    = 32'hFFFF_FFF0,
    parameter logic [31:0] BASE2    = 32'hFFFF_FFFF,
    parameter logic [31:0] MASK2    = 32'h0000_0000,
    parameter logic [31:0] BASE3    = 32'hFFFF_FFFF,
    parameter logic [31:0] MASK3    = 32'h0000_0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [31:0]  i_wb_adr,
    input  logic [31:0]  i_wb_dat,
    input  logic [3:0]   i_wb_sel,
    input  logic         i_wb_we,
    input  logic         i_wb_stb,
    input  logic         i_wb_cyc,
    output logic [31:0]  o_wb_rdt,
    output logic         o_wb_ack,
    output logic         o_wb_err,
    output logic [31:0]  o_s_adr,
    output logic [31:0]  o_s_dat,
    output logic [3:0]   o_s_sel,
    output logic         o_s_we,
    output logic [3:0]   o_s_stb,
    input  logic [127:0] i_s_rdt,
    input  logic [3:0]   i_s_ack
);

    // The counter is 8 bits wide, so a TIMEOUT outside 1..255 can never be reached.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("wb_ext_decoder: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_wb_rdt;
    logic        r_wb_ack;
    logic        r_wb_err;
    logic [31:0] r_s_adr;
    logic [31:0] r_s_dat;
    logic [3:0]  r_s_sel;
    logic        r_s_we;
    logic [3:0]  r_s_stb;

    logic [3:0]  w_hit;
    logic [3:0]  w_hit_oh;
    logic        w_ack_sel;
    logic [31:0] w_rdt_sel;

`ifdef WB_DEC_TIMEOUT_EN
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_inc;
    assign w_cnt_inc = r_cnt + 8'd1;
`endif

    // Region match is evaluated on the live master address, decoded in the accepting cycle.
    assign w_hit[0] = ((i_wb_adr & MASK0) == BASE0);
    assign w_hit[1] = ((i_wb_adr & MASK1) == BASE1);
    assign w_hit[2] = ((i_wb_adr & MASK2) == BASE2);
    assign w_hit[3] = ((i_wb_adr & MASK3) == BASE3);

    // Overlapping regions resolve to the lowest slave index.
    always_comb begin
        w_hit_oh = 4'b0000;
        if (w_hit[0])      w_hit_oh = 4'b0001;
        else if (w_hit[1]) w_hit_oh = 4'b0010;
        else if (w_hit[2]) w_hit_oh = 4'b0100;
        else if (w_hit[3]) w_hit_oh = 4'b1000;
    end

    // Only the strobed slave's ack counts; the one-hot strobe doubles as the select.
    assign w_ack_sel = |(i_s_ack & r_s_stb);

    // AND-OR read-data mux keyed by the one-hot strobe.
    always_comb begin
        w_rdt_sel = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (r_s_stb[k]) w_rdt_sel = w_rdt_sel | i_s_rdt[32*k +: 32];
        end
    end

    // Request/response FSM with all bus outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_wb_rdt <= 32'h0;
            r_wb_ack <= 1'b0;
            r_wb_err <= 1'b0;
            r_s_adr  <= 32'h0;
            r_s_dat  <= 32'h0;
            r_s_sel  <= 4'h0;
            r_s_we   <= 1'b0;
            r_s_stb  <= 4'h0;
`ifdef WB_DEC_TIMEOUT_EN
            r_cnt    <= 8'd0;
`endif
        end else begin
            r_wb_ack <= 1'b0;
            r_wb_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_wb_stb && i_wb_cyc) begin
                        r_s_adr <= i_wb_adr;
                        r_s_dat <= i_wb_dat;
                        r_s_sel <= i_wb_sel;
                        r_s_we  <= i_wb_we;
                        if (|w_hit_oh) begin
                            r_s_stb <= w_hit_oh;
                            r_state <= ST_BUSY;
`ifdef WB_DEC_TIMEOUT_EN
                            r_cnt   <= 8'd0;
`endif
                        end else begin
                            // Unmapped: answer immediately so the CPU never waits; a write is simply dropped.
                            r_wb_ack <= 1'b1;
                            r_wb_err <= 1'b1;
                            r_wb_rdt <= ERR_DATA;
                            r_state  <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!i_wb_cyc) begin
                        // Master gave up: release the slave silently, any later ack lands in IDLE.
                        r_s_stb <= 4'h0;
                        r_state <= ST_IDLE;
                    end else if (w_ack_sel) begin
                        r_wb_rdt <= w_rdt_sel;
                        r_wb_ack <= 1'b1;
                        r_s_stb  <= 4'h0;
                        r_state  <= ST_RESP;
                    end
`ifdef WB_DEC_TIMEOUT_EN
                    // An ack in the final counted cycle takes the branch above and wins over the timeout.
                    else if (w_cnt_inc == LP_TIMEOUT) begin
                        r_s_stb  <= 4'h0;
                        r_wb_ack <= 1'b1;
                        r_wb_err <= 1'b1;
                        r_wb_rdt <= ERR_DATA;
                        r_state  <= ST_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end
                ST_RESP: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_wb_rdt = r_wb_rdt;
    assign o_wb_ack = r_wb_ack;
    assign o_wb_err = r_wb_err;
    assign o_s_adr  = r_s_adr;
    assign o_s_dat  = r_s_dat;
    assign o_s_sel  = r_s_sel;
    assign o_s_we   = r_s_we;
    assign o_s_stb  = r_s_stb;

endmodule
